rr_req_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource (a single output lane) among N requesters.
- Produces a registered one-hot grant, the binary index of the granted requester, and an OR-reduced any_req flag.
- Sits between the request sources and the shared lane.
- Enforces a maximum hold time so no requester starves the others.

---
 rtl/rr_req_arbiter.sv | 122 ++++++++++++
 tb/tb_rr_req_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
// rtl/rr_req_arbiter.sv - round-robin arbiter with bounded hold time and registered one-hot grant
// Optional ARB_LOCK_EN adds a lock input that suppresses preemption while a grant is held.
module rr_req_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
`ifdef ARB_LOCK_EN
  input  logic                 lock,
`endif
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_req
);

  localparam int IDX_W = $clog2(N);
  localparam int HC_W  = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [N-1:0]    ONE       = N'(1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t            r_state, w_state_nxt;
  logic [N-1:0]      r_grant, w_grant_nxt;
  logic              r_valid, w_valid_nxt;
  logic [IDX_W-1:0]  r_idx,   w_idx_nxt;
  logic [IDX_W-1:0]  r_last,  w_last_nxt;
  logic [HC_W-1:0]   r_hold,  w_hold_nxt;
  logic [N-1:0]      w_search_req;
  logic [IDX_W-1:0]  w_pick;
  logic              w_lock;

`ifdef ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // First set bit searching upward from base+1 with wrap; base itself is checked last.
  function automatic logic [IDX_W-1:0] f_pick(input logic [N-1:0] r, input logic [IDX_W-1:0] base);
    logic [IDX_W-1:0] res;
    logic             found;
    int               j;
    res   = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      j = (int'(base) + off) % N;
      if (!found && r[j]) begin
        found = 1'b1;
        res   = IDX_W'(j);
      end
    end
    return res;
  endfunction

  // While granting, the holder is masked out so a preempt always moves to someone else.
  assign w_search_req = (r_state == ST_GRANT) ? (req & ~r_grant) : req;
  assign w_pick       = f_pick(w_search_req, r_last);
  assign any_req      = |req;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = ONE << w_pick;
          w_valid_nxt = 1'b1;
          w_idx_nxt   = w_pick;
          w_last_nxt  = w_pick;
          w_hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (!req[r_idx]) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
          w_hold_nxt  = '0;
        end else if (r_hold < HOLD_LAST) begin
          w_hold_nxt = r_hold + HC_W'(1);
        end else if ((|w_search_req) && !w_lock) begin
          w_grant_nxt = ONE << w_pick;
          w_idx_nxt   = w_pick;
          w_last_nxt  = w_pick;
          w_hold_nxt  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_last  <= IDX_W'(N - 1);
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_idx   = r_idx;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb/tb_rr_req_arbiter.sv - directed self-checking bench for rr_req_arbiter (N=4, MAX_HOLD=4)
module tb_rr_req_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       any_req;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  int n_tests;
  int n_fail;

  rr_req_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .any_req     (any_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    tick();
    tick();
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b valid=%b idx=%0d, need 0000/0/0", grant, grant_valid, grant_idx);
    end
    n_tests++;
    if (any_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_any_req: got %b need 0", any_req);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 4'b0010;
    #1;
    n_tests++;
    if (any_req !== 1'b1) begin
      n_fail++;
      $display("FAIL single_any_req: got %b need 1", any_req);
    end
    tick();
    n_tests++;
    if (grant !== 4'b0010 || grant_valid !== 1'b1 || grant_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b valid=%b idx=%0d, need 0010/1/1", grant, grant_valid, grant_idx);
    end
    req = 4'b0000;
    tick();
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL single_release: grant=%b valid=%b idx=%0d, need 0000/0/1", grant, grant_valid, grant_idx);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [1:0] exp_i;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_i = 2'((c / 4) % 4);
      exp_g = 4'b0001 << exp_i;
      n_tests++;
      if (grant !== exp_g || grant_idx !== exp_i || grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL round_robin cycle %0d: grant=%b idx=%0d valid=%b, need %b/%0d/1", c, grant, grant_idx, grant_valid, exp_g, exp_i);
      end
    end
  endtask

  task automatic test_release_bubble();
    do_reset();
    req = 4'b0101;
    tick();
    tick();
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL bubble_first: grant=%b need 0001", grant);
    end
    req = 4'b0100;
    tick();
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_idle: grant=%b valid=%b need 0000/0", grant, grant_valid);
    end
    tick();
    n_tests++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_next: grant=%b idx=%0d valid=%b need 0100/2/1", grant, grant_idx, grant_valid);
    end
  endtask

  task automatic test_saturate();
    int bad;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (grant !== 4'b0100) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL saturate_hold: %0d cycles lost grant 0100, need 0", bad);
    end
    req = 4'b1100;
    tick();
    n_tests++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL saturate_preempt: grant=%b idx=%0d need 1000/3", grant, grant_idx);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: grant=%b valid=%b idx=%0d need 0000/0/0", grant, grant_valid, grant_idx);
    end
    req = 4'b1010;
    #2;
    rst = 1'b0;
    tick();
    n_tests++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_restart: grant=%b idx=%0d valid=%b need 0010/1/1", grant, grant_idx, grant_valid);
    end
  endtask

  task automatic test_release_beats_preempt();
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 4; c++) tick();
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL timeout_hold: grant=%b need 0001", grant);
    end
    req = 4'b0010;
    tick();
    n_tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_beats_preempt: grant=%b valid=%b need 0000/0", grant, grant_valid);
    end
    tick();
    n_tests++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL release_then_grant: grant=%b idx=%0d need 0010/1", grant, grant_idx);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    int bad;
    bad = 0;
    do_reset();
    lock = 1'b1;
    req  = 4'b0011;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (grant !== 4'b0001) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL lock_hold: %0d cycles lost grant 0001, need 0", bad);
    end
    lock = 1'b0;
    tick();
    n_tests++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL lock_release: grant=%b idx=%0d need 0010/1", grant, grant_idx);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_release_bubble();
    test_saturate();
    test_async_reset();
    test_release_beats_preempt();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
